// File: rtl/mem_sequencer.sv
// Steps a single-cycle core through fetch / execute / load-data phases on one shared
// synchronous-read memory port. Optional perf counters: define MEM_SEQ_PERF_EN.
module mem_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  input  logic                  data_rd_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stall_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           perf_retired_o,
  output logic [31:0]           perf_stall_o
);

  typedef enum logic [1:0] {FETCH, WAIT_I, EXEC, WAIT_D} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      inst_q <= NOP_INST;
    end else begin
      state <= state_nxt;
      if (state == WAIT_I) inst_q <= mem_rdata_i;
    end
  end

  assign inst_o = inst_q;

  always_comb begin
    state_nxt   = state;
    stall_o     = 1'b1;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    data_o      = '0;
    unique case (state)
      FETCH: begin
        mem_ce_o   = 1'b1;
        mem_addr_o = inst_addr_i;
        state_nxt  = WAIT_I;
      end
      WAIT_I: state_nxt = EXEC;
      EXEC: begin
        // store has priority over a simultaneous load request
        if (data_we_i) begin
          mem_ce_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
          stall_o     = 1'b0;
          state_nxt   = FETCH;
        end else if (data_rd_i) begin
          mem_ce_o   = 1'b1;
          mem_addr_o = data_addr_i;
          state_nxt  = WAIT_D;
        end else begin
          stall_o   = 1'b0;
          state_nxt = FETCH;
        end
      end
      WAIT_D: begin
        data_o    = mem_rdata_i;
        stall_o   = 1'b0;
        state_nxt = FETCH;
      end
    endcase
    // reset kills any in-flight access or retirement in the same cycle
    if (rst) begin
      stall_o     = 1'b1;
      mem_ce_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      data_o      = '0;
    end
  end

`ifdef MEM_SEQ_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (stall_o) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign perf_retired_o = retired_q;
  assign perf_stall_o   = stall_q;
`else
  assign perf_retired_o = '0;
  assign perf_stall_o   = '0;
`endif

endmodule
